rom_access_arbiter: RTL and testbench

- Shares the single 32-word instruction ROM between two requesters:
  - CPU instruction-fetch port (fetch_*).
  - Debug/loader read port (dbg_*), used by the monitor to dump program memory.
- Owns the ROM's address and chip_select, and registers ROM read data back to the winning requester.
- Fetch has fixed priority. A starvation counter guarantees debug progress.
- Sits between the control unit / debug monitor and the ROM.

---
 rtl/rom_access_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rom_access_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares the single instruction ROM between the CPU fetch port
// and the debug/loader read port. Fetch has fixed priority; a starvation counter
// hands debug the next arbitration after STARVE_LIMIT consecutive fetch grants
// won while debug was waiting.
// Optional macro ROM_WAIT_STATE_EN inserts a WAIT state between ACCESS and RESP so
// the ROM gets two cycles of stable address/select before its data is captured.
module rom_access_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_valid,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_chip_select,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

`ifdef ROM_WAIT_STATE_EN
    // ROM data is sampled at the end of the last cycle the ROM is driven.
    localparam state_t LAST_ROM_STATE = ST_WAIT;
    localparam state_t AFTER_ACCESS   = ST_WAIT;
`else
    localparam state_t LAST_ROM_STATE = ST_ACCESS;
    localparam state_t AFTER_ACCESS   = ST_RESP;
`endif

    // FSM and transaction context
    state_t                  state_reg, state_next;
    logic                    grant_dbg_reg, grant_dbg_next;   // 1: debug owns the current read
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;             // latched winner address
    logic [3:0]              starve_cnt_reg, starve_cnt_next;

    // Registered outputs (all driven straight from flops so the ROM sees no glitches)
    logic                    rom_cs_reg, rom_cs_next;
    logic [ADDR_WIDTH-1:0]   rom_addr_reg, rom_addr_next;
    logic                    fetch_valid_reg, fetch_valid_next;
    logic                    dbg_valid_reg, dbg_valid_next;
    logic [DATA_WIDTH-1:0]   fetch_data_reg, fetch_data_next;
    logic [DATA_WIDTH-1:0]   dbg_data_reg, dbg_data_next;
    logic                    busy_reg, busy_next;

    logic                    starve_at_limit;
    logic                    dbg_wins;

    assign starve_at_limit = (starve_cnt_reg == STARVE_LIMIT_C);
    // Debug wins when it is alone, or when it has been passed over too often.
    assign dbg_wins        = dbg_req && (!fetch_req || starve_at_limit);

    // State and transaction-context registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            grant_dbg_reg  <= 1'b0;
            addr_reg       <= '0;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            grant_dbg_reg  <= grant_dbg_next;
            addr_reg       <= addr_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Next-state logic: arbitration happens only in IDLE, so RESP never re-accepts a request
    always_comb begin
        state_next      = state_reg;
        grant_dbg_next  = grant_dbg_reg;
        addr_next       = addr_reg;
        starve_cnt_next = starve_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fetch_req || dbg_req) begin
                    state_next = ST_ACCESS;
                    if (dbg_wins) begin
                        grant_dbg_next  = 1'b1;
                        addr_next       = dbg_addr;
                        starve_cnt_next = '0;
                    end else begin
                        grant_dbg_next = 1'b0;
                        addr_next      = fetch_addr;
                        // Only grants that make debug wait count towards starvation.
                        if (dbg_req && (starve_cnt_reg < STARVE_LIMIT_C)) begin
                            starve_cnt_next = starve_cnt_reg + 4'd1;
                        end
                    end
                end
            end
            ST_ACCESS: state_next = AFTER_ACCESS;
            ST_WAIT:   state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the next state
    always_comb begin
        rom_cs_next      = (state_next == ST_ACCESS) || (state_next == ST_WAIT);
        rom_addr_next    = rom_cs_next ? addr_next : '0;
        fetch_valid_next = (state_next == ST_RESP) && !grant_dbg_next;
        dbg_valid_next   = (state_next == ST_RESP) && grant_dbg_next;
        busy_next        = (state_next != ST_IDLE);
        fetch_data_next  = fetch_data_reg;
        dbg_data_next    = dbg_data_reg;
        // Only the winner's data register is ever written.
        if (state_reg == LAST_ROM_STATE) begin
            if (grant_dbg_reg) begin
                dbg_data_next = rom_data;
            end else begin
                fetch_data_next = rom_data;
            end
        end
    end

    // Output registers; reset drops any read in flight without a valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_cs_reg      <= 1'b0;
            rom_addr_reg    <= '0;
            fetch_valid_reg <= 1'b0;
            dbg_valid_reg   <= 1'b0;
            fetch_data_reg  <= '0;
            dbg_data_reg    <= '0;
            busy_reg        <= 1'b0;
        end else begin
            rom_cs_reg      <= rom_cs_next;
            rom_addr_reg    <= rom_addr_next;
            fetch_valid_reg <= fetch_valid_next;
            dbg_valid_reg   <= dbg_valid_next;
            fetch_data_reg  <= fetch_data_next;
            dbg_data_reg    <= dbg_data_next;
            busy_reg        <= busy_next;
        end
    end

    assign rom_chip_select = rom_cs_reg;
    assign rom_address     = rom_addr_reg;
    assign fetch_valid     = fetch_valid_reg;
    assign dbg_valid       = dbg_valid_reg;
    assign fetch_data      = fetch_data_reg;
    assign dbg_data        = dbg_data_reg;
    assign busy            = busy_reg;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter: vector table, hand-written corner
// sequences (simultaneous requests, starvation, reset mid-read, debug dump) and a
// random phase checked against a transaction-timing model of the arbiter.
`timescale 1ns/1ps
module tb_rom_access_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
`ifdef ROM_WAIT_STATE_EN
    localparam int LAT = 3;   // sample edge -> valid cycle distance
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          dbg_req = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic          dbg_valid;
    logic [DW-1:0] dbg_data;
    logic [AW-1:0] rom_address;
    logic          rom_chip_select;
    logic [DW-1:0] rom_data;
    logic          busy;

    logic [DW-1:0] rom_mem [0:31];

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] fd_exp = '0;
    logic [DW-1:0] dd_exp = '0;

    always #5 clk = ~clk;

    // ROM: combinational read; a junk pattern stands in for the floating bus when deselected
    assign rom_data = rom_chip_select ? rom_mem[rom_address] : 32'hBAD0_0BAD;

    rom_access_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_valid      (dbg_valid),
        .dbg_data       (dbg_data),
        .rom_address    (rom_address),
        .rom_chip_select(rom_chip_select),
        .rom_data       (rom_data),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " cs"}, 32'(rom_chip_select), 32'd0);
        check({name, " addr"}, 32'(rom_address), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " fetch_valid"}, 32'(fetch_valid), 32'd0);
        check({name, " dbg_valid"}, 32'(dbg_valid), 32'd0);
        check({name, " fetch_data"}, fetch_data, 32'd0);
        check({name, " dbg_data"}, dbg_data, 32'd0);
    endtask

    // Returns at a negedge right after reset release, requests idle
    task automatic do_reset();
        fetch_req = 1'b0;
        dbg_req   = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fd_exp = '0;
        dd_exp = '0;
    endtask

    // One isolated read from IDLE; the loser (if any) withdraws at the winner's valid
    task automatic run_txn(input logic freq, input logic [AW-1:0] fa, input logic dreq,
                           input logic [AW-1:0] da, input logic exp_dbg, input string name);
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        wa = exp_dbg ? da : fa;
        wd = rom_mem[wa];
        fetch_req  = freq;
        fetch_addr = fa;
        dbg_req    = dreq;
        dbg_addr   = da;
        @(negedge clk);
        check({name, " access cs"}, 32'(rom_chip_select), 32'd1);
        check({name, " access addr"}, 32'(rom_address), 32'(wa));
        for (int w = 1; w < LAT - 1; w++) begin
            @(negedge clk);
            check({name, " wait cs"}, 32'(rom_chip_select), 32'd1);
            check({name, " wait addr"}, 32'(rom_address), 32'(wa));
            check({name, " wait valids"}, 32'({fetch_valid, dbg_valid}), 32'd0);
        end
        @(negedge clk);
        if (exp_dbg) dd_exp = wd;
        else         fd_exp = wd;
        check({name, " fetch_valid"}, 32'(fetch_valid), 32'(!exp_dbg));
        check({name, " dbg_valid"}, 32'(dbg_valid), 32'(exp_dbg));
        check({name, " fetch_data"}, fetch_data, fd_exp);
        check({name, " dbg_data"}, dbg_data, dd_exp);
        check({name, " resp cs"}, 32'(rom_chip_select), 32'd0);
        check({name, " resp addr"}, 32'(rom_address), 32'd0);
        fetch_req = 1'b0;
        dbg_req   = 1'b0;
        @(negedge clk);
        check({name, " idle valids"}, 32'({fetch_valid, dbg_valid}), 32'd0);
        check({name, " idle busy"}, 32'(busy), 32'd0);
        $display("txn %s: winner=%s addr=%0d data=%h", name, exp_dbg ? "dbg" : "fetch", wa, wd);
    endtask

    typedef struct {
        logic          freq;
        logic [AW-1:0] fa;
        logic          dreq;
        logic [AW-1:0] da;
        logic          exp_dbg;
    } vec_t;

    vec_t vecs [11];

    // Random-phase state
    int            cyc, nxt, se, sc, nrand;
    logic          sw;
    logic [AW-1:0] sa;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv_at, dv_at, fcnt, dcnt, both, run_f, nd, spurious;
        bit got;
        logic e_cs, e_fv, e_dv, e_busy;
        logic [AW-1:0] e_addr;

        for (int i = 0; i < 32; i++) begin
            rom_mem[i] = {8'(i + 1), 8'(~i), 16'(i * 16'h1357 + 16'h2468)};
        end
        rom_mem[3] = 32'hDEAD_BEEF;

        // Starting at counter 0: four contended fetch wins, then debug takes one.
        vecs[0]  = '{1'b1, 5'd3,  1'b0, 5'd0,  1'b0};
        vecs[1]  = '{1'b0, 5'd0,  1'b1, 5'd5,  1'b1};
        vecs[2]  = '{1'b1, 5'd1,  1'b1, 5'd2,  1'b0};
        vecs[3]  = '{1'b1, 5'd9,  1'b0, 5'd4,  1'b0};
        vecs[4]  = '{1'b1, 5'd10, 1'b1, 5'd11, 1'b0};
        vecs[5]  = '{1'b1, 5'd12, 1'b1, 5'd13, 1'b0};
        vecs[6]  = '{1'b1, 5'd14, 1'b1, 5'd15, 1'b0};
        vecs[7]  = '{1'b1, 5'd16, 1'b1, 5'd17, 1'b1};
        vecs[8]  = '{1'b1, 5'd18, 1'b1, 5'd19, 1'b0};
        vecs[9]  = '{1'b0, 5'd8,  1'b1, 5'd31, 1'b1};
        vecs[10] = '{1'b1, 5'd0,  1'b1, 5'd1,  1'b0};

        // Reset state
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Vector table
        do_reset();
        for (int v = 0; v < 11; v++) begin
            run_txn(vecs[v].freq, vecs[v].fa, vecs[v].dreq, vecs[v].da, vecs[v].exp_dbg,
                    $sformatf("vec%0d", v));
        end

        // Simultaneous requests: fetch first, debug at the next arbitration
        do_reset();
        fetch_addr = 5'd1; dbg_addr = 5'd2; fetch_req = 1'b1; dbg_req = 1'b1;
        fv_at = -1; dv_at = -1; fcnt = 0; dcnt = 0; both = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (fetch_valid && dbg_valid) both++;
            if (fetch_valid) begin
                fcnt++; fv_at = c; fetch_req = 1'b0;
                check("simul fetch_data", fetch_data, rom_mem[1]);
            end
            if (dbg_valid) begin
                dcnt++; dv_at = c; dbg_req = 1'b0;
                check("simul dbg_data", dbg_data, rom_mem[2]);
            end
        end
        check("simul fetch valid cycle", 32'(fv_at), 32'(LAT - 1));
        check("simul dbg valid cycle", 32'(dv_at), 32'(2 * LAT));
        check("simul valid counts", 32'({fcnt[7:0], dcnt[7:0]}), 32'h0101);
        check("simul overlapping valids", 32'(both), 32'd0);
        $display("txn simul: fetch valid @%0d, dbg valid @%0d", fv_at, dv_at);

        // Starvation: both held high, two rounds to show the counter clears
        do_reset();
        fetch_addr = 5'd0; dbg_addr = 5'd20; fetch_req = 1'b1; dbg_req = 1'b1;
        run_f = 0; nd = 0;
        for (int c = 0; c < 200 && nd < 2; c++) begin
            @(negedge clk);
            if (fetch_valid) begin
                check("starve fetch_data", fetch_data, rom_mem[fetch_addr]);
                run_f++;
                fetch_addr = fetch_addr + 5'd1;
            end
            if (dbg_valid) begin
                check("starve dbg_data", dbg_data, rom_mem[dbg_addr]);
                check("starve fetch grants before dbg", 32'(run_f), 32'(LIMIT));
                $display("txn starve: dbg granted after %0d fetch grants", run_f);
                run_f = 0; nd++;
                dbg_addr = dbg_addr + 5'd1;
            end
        end
        check("starve dbg grants", 32'(nd), 32'd2);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (dbg_valid) break;
            if (fetch_valid) got = 1'b1;
        end
        check("starve fetch resumes", 32'(got), 32'd1);
        fetch_req = 1'b0; dbg_req = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Reset in the middle of a read
        do_reset();
        run_txn(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, "pre-reset");
        fetch_req = 1'b1; fetch_addr = 5'd6;
        @(negedge clk);
        check("midreset access cs", 32'(rom_chip_select), 32'd1);
        check("midreset access addr", 32'(rom_address), 32'd6);
        #2 reset_n = 1'b0; fetch_req = 1'b0;
        #1 check_all_zero("midreset async");
        fd_exp = '0; dd_exp = '0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (fetch_valid || dbg_valid) spurious++;
        end
        check("midreset no stale valid", 32'(spurious), 32'd0);
        run_txn(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, "post-reset");

        // Debug dump of the whole ROM, wrapping past the last address
        for (int i = 0; i <= 32; i++) begin
            run_txn(1'b0, 5'd0, 1'b1, 5'(i), 1'b1, $sformatf("dump%0d", i));
        end

        // Random phase against a transaction-timing model
        do_reset();
        cyc = 0; nxt = 1; se = -100; sc = 0; sw = 1'b0; sa = '0; nrand = 0;
        for (int k = 0; k < 600; k++) begin
            // Requesters react to the valid the model predicts for the current cycle
            e_fv = (cyc == se + LAT - 1) && !sw;
            e_dv = (cyc == se + LAT - 1) && sw;
            if (e_fv) begin
                fetch_req = ($urandom_range(1, 0) == 1);
                fetch_addr = 5'($urandom);
            end else if (!fetch_req && $urandom_range(2, 0) == 0) begin
                fetch_req = 1'b1;
                fetch_addr = 5'($urandom);
            end
            if (e_dv) begin
                dbg_req = ($urandom_range(1, 0) == 1);
                dbg_addr = 5'($urandom);
            end else if (!dbg_req && $urandom_range(2, 0) == 0) begin
                dbg_req = 1'b1;
                dbg_addr = 5'($urandom);
            end
            // Arbitration decision for the coming edge
            if ((cyc + 1 >= nxt) && (fetch_req || dbg_req)) begin
                sw = dbg_req && (!fetch_req || sc == LIMIT);
                if (sw) sc = 0;
                else if (dbg_req && sc < LIMIT) sc++;
                sa  = sw ? dbg_addr : fetch_addr;
                se  = cyc + 1;
                nxt = se + LAT + 1;
            end
            @(negedge clk);
            cyc++;
            e_cs   = (cyc >= se) && (cyc <= se + LAT - 2);
            e_addr = e_cs ? sa : '0;
            e_fv   = (cyc == se + LAT - 1) && !sw;
            e_dv   = (cyc == se + LAT - 1) && sw;
            e_busy = (cyc >= se) && (cyc <= se + LAT - 1);
            if (e_fv) fd_exp = rom_mem[sa];
            if (e_dv) dd_exp = rom_mem[sa];
            check("rand cs", 32'(rom_chip_select), 32'(e_cs));
            check("rand addr", 32'(rom_address), 32'(e_addr));
            check("rand fetch_valid", 32'(fetch_valid), 32'(e_fv));
            check("rand dbg_valid", 32'(dbg_valid), 32'(e_dv));
            check("rand busy", 32'(busy), 32'(e_busy));
            check("rand fetch_data", fetch_data, fd_exp);
            check("rand dbg_data", dbg_data, dd_exp);
            if (e_fv || e_dv) begin
                nrand++;
                $display("txn rand%0d: winner=%s addr=%0d data=%h", nrand,
                         sw ? "dbg" : "fetch", sa, rom_mem[sa]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
